// File: rtl/pixel_write_queue.sv
// rtl/pixel_write_queue.sv - pixel write queue draining into a shared framebuffer write port
//
// Ports:
//   clk, reset          sole clock; synchronous active-high reset
//   write_strobe        one-cycle pixel write request with write_x / write_y / write_color
//   fb_busy             display scan owns the framebuffer port this cycle
//   fb_we               registered write enable, one cycle per pixel
//   fb_addr, fb_wdata   registered write address (y*FB_W+x) and colour; zero while fb_we=0
//   fifo_full/empty     registered occupancy flags
//   overflow            sticky: an in-range strobe was dropped because the queue was full
//   drop_count          (PIXEL_WRITE_QUEUE_DROP_COUNT_EN only) saturating count of dropped strobes
module pixel_write_queue #(
    parameter int FIFO_DEPTH = 8,
    parameter int FB_W       = 64,
    parameter int FB_H       = 64,
    parameter int ADDR_W     = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_strobe,
    input  logic [6:0]        write_x,
    input  logic [6:0]        write_y,
    input  logic [7:0]        write_color,
    input  logic              fb_busy,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [7:0]        fb_wdata,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              overflow
`ifdef PIXEL_WRITE_QUEUE_DROP_COUNT_EN
    ,
    output logic [7:0]        drop_count
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, WRITE} state_t;

    state_t            state;
    state_t            state_next;
    logic [21:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;

    logic              in_range;
    logic              strobe_ok;
    logic              queued;
    logic              avail;
    logic              pop;
    logic              push;
    logic              drop;
    logic [21:0]       head;
    logic [ADDR_W-1:0] head_addr;

    assign in_range  = (32'(write_x) < FB_W) && (32'(write_y) < FB_H);
    assign strobe_ok = write_strobe && in_range;
    assign queued    = (count != '0);

    // An in-range strobe arriving at an empty queue is treated as the head
    // entry straight away, so it can be written the very next cycle.
    assign avail = queued || strobe_ok;
    assign pop   = avail && !fb_busy;
    // When full, the slot freed by a same-cycle pop is reused by the push.
    assign push  = strobe_ok && (!fifo_full || pop);
    assign drop  = strobe_ok && fifo_full && !pop;

    assign head      = queued ? mem[rd_ptr] : {write_x, write_y, write_color};
    assign head_addr = ADDR_W'(head[14:8]) * ADDR_W'(FB_W) + ADDR_W'(head[21:15]);

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    assign fb_we      = (state == WRITE);

    always_comb begin
        state_next = IDLE;
        if (pop) begin
            state_next = WRITE;
        end else if (avail) begin
            state_next = WAIT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            fb_addr  <= '0;
            fb_wdata <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_next;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
            fb_addr  <= pop ? head_addr : '0;
            fb_wdata <= pop ? head[7:0] : '0;
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage has no reset; occupancy and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {write_x, write_y, write_color};
        end
    end

`ifdef PIXEL_WRITE_QUEUE_DROP_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= '0;
        end else if (drop && drop_count != 8'hFF) begin
            drop_count <= drop_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pixel_write_queue.sv
// tb/tb_pixel_write_queue.sv - scoreboard bench for pixel_write_queue
module tb_pixel_write_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        write_strobe = 1'b0;
    logic [6:0]  write_x = '0;
    logic [6:0]  write_y = '0;
    logic [7:0]  write_color = '0;
    logic        fb_busy = 1'b0;
    logic        fb_we;
    logic [11:0] fb_addr;
    logic [7:0]  fb_wdata;
    logic        fifo_full;
    logic        fifo_empty;
    logic        overflow;
`ifdef PIXEL_WRITE_QUEUE_DROP_COUNT_EN
    logic [7:0]  drop_count;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [19:0] sb[$];

    pixel_write_queue dut (
        .clk(clk),
        .reset(reset),
        .write_strobe(write_strobe),
        .write_x(write_x),
        .write_y(write_y),
        .write_color(write_color),
        .fb_busy(fb_busy),
        .fb_we(fb_we),
        .fb_addr(fb_addr),
        .fb_wdata(fb_wdata),
        .fifo_full(fifo_full),
        .fifo_empty(fifo_empty),
        .overflow(overflow)
`ifdef PIXEL_WRITE_QUEUE_DROP_COUNT_EN
        ,
        .drop_count(drop_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int x, input int y, input int c, input bit expect_write);
        write_strobe = 1'b1;
        write_x      = 7'(x);
        write_y      = 7'(y);
        write_color  = 8'(c);
        if (expect_write) begin
            sb.push_back({12'(y * 64 + x), 8'(c)});
        end
        tick();
        write_strobe = 1'b0;
    endtask

    // Monitor: every fb_we cycle must match the oldest expected write.
    always @(negedge clk) begin
        logic [19:0] exp;
        if (fb_we === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got addr %0d data %0d, expected no write", fb_addr, fb_wdata);
            end else begin
                exp = sb.pop_front();
                check("write_addr", 32'(fb_addr), 32'(exp[19:8]));
                check("write_data", 32'(fb_wdata), 32'(exp[7:0]));
            end
        end else begin
            check("idle_outputs_zero", {12'd0, fb_addr, fb_wdata}, 32'd0);
        end
    end

    initial begin
        int writes;
        logic busy_prev;

        // Reset state
        repeat (3) tick();
        check("rst_we", 32'(fb_we), 32'd0);
        check("rst_empty", 32'(fifo_empty), 32'd1);
        check("rst_full", 32'(fifo_full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        tick();

        // Single pixel, minimum latency: addr 2*64+3 = 131
        fb_busy = 1'b0;
        send(3, 2, 8'hA5, 1'b1);
        check("latency_we", 32'(fb_we), 32'd1);
        check("latency_addr", 32'(fb_addr), 32'd131);
        tick();
        check("single_we_off", 32'(fb_we), 32'd0);
        check("single_empty", 32'(fifo_empty), 32'd1);

        // Out-of-range strobes are discarded
        send(64, 0, 8'h11, 1'b0);
        send(0, 70, 8'h22, 1'b0);
        repeat (3) tick();
        check("oor_empty", 32'(fifo_empty), 32'd1);
        check("oor_overflow", 32'(overflow), 32'd0);

        // Nine strobes while blocked: eight queued, one dropped
        fb_busy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            send(10 + i, 1 + i, 16 + i, i < 8);
        end
        check("block_full", 32'(fifo_full), 32'd1);
        check("block_overflow", 32'(overflow), 32'd1);
`ifdef PIXEL_WRITE_QUEUE_DROP_COUNT_EN
        check("block_drop_count", 32'(drop_count), 32'd1);
`endif
        fb_busy = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("burst_we", 32'(fb_we), 32'd1);
        end
        tick();
        check("burst_end_we", 32'(fb_we), 32'd0);
        check("burst_end_empty", 32'(fifo_empty), 32'd1);

        // Reset clears sticky overflow
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("overflow_cleared", 32'(overflow), 32'd0);

        // Full queue, push on the pop cycle is accepted
        fb_busy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(20 + i, 30 + i, 8'h40 + i, 1'b1);
        end
        check("fill_full", 32'(fifo_full), 32'd1);
        fb_busy = 1'b0;
        send(5, 6, 8'h77, 1'b1);
        check("pushpop_full", 32'(fifo_full), 32'd1);
        check("pushpop_we", 32'(fb_we), 32'd1);
        repeat (10) tick();
        check("pushpop_overflow", 32'(overflow), 32'd0);
        check("pushpop_empty", 32'(fifo_empty), 32'd1);
        check("pushpop_drained", 32'(sb.size()), 32'd0);

        // fb_busy toggling every cycle with four queued pixels
        fb_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(40 + i, 50 + i, 8'h80 + i, 1'b1);
        end
        writes = 0;
        for (int k = 0; k < 12; k++) begin
            fb_busy   = 1'(k & 1);
            busy_prev = fb_busy;
            tick();
            if (fb_we) begin
                writes++;
                check("we_in_free_cycle", 32'(busy_prev), 32'd0);
            end
        end
        check("toggle_write_count", 32'(writes), 32'd4);

        // Reset while waiting with five entries; coincident strobe ignored
        fb_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(60 + i, 10 + i, 8'hC0 + i, 1'b0);
        end
        repeat (2) tick();
        check("wait_not_empty", 32'(fifo_empty), 32'd0);
        reset        = 1'b1;
        fb_busy      = 1'b0;
        write_strobe = 1'b1;
        write_x      = 7'd1;
        write_y      = 7'd1;
        write_color  = 8'hEE;
        tick();
        reset        = 1'b0;
        write_strobe = 1'b0;
        check("abandon_we", 32'(fb_we), 32'd0);
        check("abandon_empty", 32'(fifo_empty), 32'd1);
        check("abandon_full", 32'(fifo_full), 32'd0);
        check("abandon_overflow", 32'(overflow), 32'd0);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("abandon_we_quiet", 32'(fb_we), 32'd0);
        end
        check("abandon_empty_after", 32'(fifo_empty), 32'd1);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pixel_write_queue.md
PIXEL_WRITE_QUEUE -- requirements
Module: pixel_write_queue

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, entry count; SHALL be a power of two, minimum 2.
REQ-002 Parameter FB_W, default 64, framebuffer width in pixels.
REQ-003 Parameter FB_H, default 64, framebuffer height in pixels.
REQ-004 Parameter ADDR_W, default 12, framebuffer address width; SHALL satisfy 2^ADDR_W >= FB_W*FB_H.
REQ-005 clk  in  1  sole clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 write_strobe  in  1  one-cycle pixel write request from the draw engine.
REQ-008 write_x  in  7  pixel column, sampled with write_strobe.
REQ-009 write_y  in  7  pixel row, sampled with write_strobe.
REQ-010 write_color  in  8  pixel colour, sampled with write_strobe.
REQ-011 fb_busy  in  1  display scan owns the framebuffer port this cycle; no write may issue.
REQ-012 fb_we  out  1  framebuffer write enable, one cycle per pixel.
REQ-013 fb_addr  out  ADDR_W  write address, valid while fb_we=1.
REQ-014 fb_wdata  out  8  write data, valid while fb_we=1.
REQ-015 fifo_full  out  1  queue holds FIFO_DEPTH entries.
REQ-016 fifo_empty  out  1  queue holds zero entries.
REQ-017 overflow  out  1  sticky flag: an in-range strobe was lost because the queue was full.

Function
REQ-018 Strobe with write_x<FB_W and write_y<FB_H SHALL push {x,y,color} unless the queue is full with no pop in the same cycle.
REQ-019 Strobe with write_x>=FB_W or write_y>=FB_H SHALL be discarded, never pushed, never setting overflow.
REQ-020 Push while full with a pop in the same cycle SHALL be accepted; occupancy stays FIFO_DEPTH.
REQ-021 Push while full with no pop SHALL be dropped and SHALL set overflow; overflow clears only on reset.
REQ-022 Drain FSM states: IDLE (queue empty), WAIT (entry pending, fb_busy=1), WRITE (fb_we=1).
REQ-023 IDLE->WRITE when queue non-empty and fb_busy=0; IDLE->WAIT when queue non-empty and fb_busy=1.
REQ-024 WAIT->WRITE on first cycle fb_busy=0; stays in WAIT otherwise.
REQ-025 WRITE lasts exactly one cycle; the head entry SHALL pop at the transition into WRITE.
REQ-026 From WRITE: next entry available and fb_busy=0 -> WRITE (back-to-back, one pixel per cycle); available and fb_busy=1 -> WAIT; none -> IDLE.
REQ-027 fb_addr SHALL equal write_y*FB_W + write_x, computed at ADDR_W bits without truncation of valid coordinates.
REQ-028 fb_we, fb_addr, fb_wdata SHALL be registered; minimum latency strobe (cycle N) to fb_we (cycle N+1) with empty queue and fb_busy=0.
REQ-029 fb_addr and fb_wdata SHALL be 0 whenever fb_we=0.
REQ-030 Pixels SHALL reach the framebuffer in strobe order; none duplicated.
REQ-031 fifo_full and fifo_empty SHALL reflect registered occupancy, updated the cycle after the push/pop.
REQ-032 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter SHALL be log2(FIFO_DEPTH)+1 bits.

Reset
REQ-033 reset=1 SHALL force: FSM IDLE, occupancy 0, pointers 0, fb_we=0, fb_addr=0, fb_wdata=0, fifo_empty=1, fifo_full=0, overflow=0.
REQ-034 reset asserted during WRITE or WAIT SHALL abandon all queued entries; no fb_we in the cycle after reset is sampled high.
REQ-035 write_strobe coincident with reset SHALL be ignored.

Configuration
REQ-036 Macro PIXEL_WRITE_QUEUE_DROP_COUNT_EN: when defined, add output drop_count (8 bits) counting strobes lost per REQ-021, saturating at 255, cleared by reset.
REQ-037 When PIXEL_WRITE_QUEUE_DROP_COUNT_EN is undefined, drop_count port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-038 Reset, then strobe x=3,y=2,color=0xA5, fb_busy=0 -> next cycle fb_we=1, fb_addr=131, fb_wdata=0xA5; then IDLE, fifo_empty=1.
REQ-039 Hold fb_busy=1, strobe 9 in-range pixels on consecutive cycles (depth 8) -> fifo_full=1, overflow=1, drop_count=1; release fb_busy -> 8 consecutive fb_we cycles, first 8 pixels in order.
REQ-040 Strobe x=64,y=0 and x=0,y=70 -> no fb_we, fifo_empty stays 1, overflow stays 0.
REQ-041 Queue full, fb_busy=0, strobe on the pop cycle -> strobe accepted, overflow stays 0, all 9 pixels written in order.
REQ-042 Toggle fb_busy 1/0 every cycle with 4 queued pixels -> fb_we only in fb_busy=0 cycles, 4 writes total, correct order.
REQ-043 Assert reset while 5 entries queued and in WAIT -> fb_we stays 0 afterwards, fifo_empty=1, overflow=0.
